// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundle of the fetch unit's bus-side signals: the instruction-memory
//   req/ack channel, the redirect input from branch/jump resolution and the
//   valid/ready channel toward decode.
//
//   modport master : the fetch unit itself
//   modport slave  : the environment (instruction memory + decode + branch)
//
//   Signals
//     imem_req    fetch request (fetch unit -> memory)
//     imem_addr   word address of the request, stable while imem_req is high
//     imem_ack    request completes this cycle (memory -> fetch unit)
//     imem_rdata  instruction word, valid with imem_req & imem_ack
//     redirect    one-cycle pulse, branch/jump taken
//     redirect_pc new fetch word address, valid with redirect
//     instr_valid head entry valid (fetch unit -> decode)
//     instr       instruction word at the head
//     instr_pc    word address of instr
//     instr_ready decode accepts the head entry this cycle
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Prefetching instruction-fetch front end. Owns the fetch PC (a word
//   address), issues one outstanding word read at a time to instruction
//   memory, buffers returned words with their PC in a DEPTH-entry FIFO and
//   hands them to decode over valid/ready. A redirect empties the FIFO and
//   restarts fetch at redirect_pc; if a request is still waiting for its ack
//   the unit holds it (FLUSH) and discards its data before switching.
//
//   Parameters
//     DEPTH   FIFO entries, power of two, 2..16
//
//   Ports
//     CLK     clock, rising edge
//     RESET   asynchronous active-low reset
//     startPC boot word address, sampled on the first edge out of reset
//     bus     instr_fetch_unit_if.master (imem req/ack, redirect, decode)
//
//   Optional feature (macro FETCH_BYPASS_EN)
//     When defined, a word acked while the FIFO is empty is presented to
//     decode in the same cycle straight from imem_rdata/imem_addr; if decode
//     takes it, it is never written into the FIFO. Suppressed in FLUSH and
//     in any cycle carrying a redirect. When undefined there is no
//     combinational path from imem_* to instr_*.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [31:0]               startPC,
    instr_fetch_unit_if.master        bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_fetch_pc, w_fetch_pc_nxt;
    logic [31:0] r_target, w_target_nxt;
    logic [AW:0] r_wptr, w_wptr_nxt;
    logic [AW:0] r_rptr, w_rptr_nxt;
    logic [AW:0] w_count;

    logic [31:0] r_pc_mem   [DEPTH];
    logic [31:0] r_word_mem [DEPTH];

    logic        w_req;
    logic        w_fetch_done;
    logic        w_fifo_valid;
    logic        w_pop;
    logic        w_push;
    logic        w_byp;

    // Extra pointer bit distinguishes full from empty.
    assign w_count      = r_wptr - r_rptr;
    assign w_fifo_valid = (r_wptr != r_rptr);

    // In FLUSH the stale request is held up until its ack arrives; in RUN a
    // request is only raised when there is room for its word. Count can only
    // drop while a request waits, so a raised request is never withdrawn.
    assign w_req        = (r_state == S_FLUSH) ||
                          ((r_state == S_RUN) && (w_count != FULL));
    assign w_fetch_done = w_req & bus.imem_ack;

`ifdef FETCH_BYPASS_EN
    assign w_byp = !w_fifo_valid && (r_state == S_RUN) && w_fetch_done &&
                   !bus.redirect;
`else
    assign w_byp = 1'b0;
`endif

    assign w_pop = w_fifo_valid & bus.instr_ready;

    // -----------------------------------------------------------------------
    // Outputs. Head data is gated with valid so that an empty FIFO shows 0
    // rather than whatever stale entry the read pointer lands on.
    // -----------------------------------------------------------------------
    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.instr_valid = w_fifo_valid | w_byp;
    assign bus.instr       = w_byp        ? bus.imem_rdata :
                             w_fifo_valid ? r_word_mem[r_rptr[AW-1:0]] : 32'd0;
    assign bus.instr_pc    = w_byp        ? r_fetch_pc :
                             w_fifo_valid ? r_pc_mem[r_rptr[AW-1:0]] : 32'd0;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_target_nxt   = r_target;
        w_wptr_nxt     = r_wptr;
        w_rptr_nxt     = r_rptr;
        w_push         = 1'b0;

        unique case (r_state)
            S_BOOT: begin
                // First edge with reset released; redirect is not looked at.
                w_fetch_pc_nxt = startPC;
                w_state_nxt    = S_RUN;
            end

            S_RUN: begin
                if (bus.redirect) begin
                    // Empty the FIFO; a same-edge dequeue does not matter.
                    w_rptr_nxt   = r_wptr;
                    w_target_nxt = bus.redirect_pc;
                    if (w_req && !bus.imem_ack) begin
                        // Request in flight: keep it up, drop its data later.
                        w_state_nxt = S_FLUSH;
                    end else begin
                        // Nothing pending, or the ack lands now and is dropped.
                        w_fetch_pc_nxt = bus.redirect_pc;
                    end
                end else begin
                    if (w_fetch_done) begin
                        w_fetch_pc_nxt = r_fetch_pc + 32'd1;
                        // A bypassed word taken by decode never enters the FIFO.
                        w_push = !(w_byp && bus.instr_ready);
                    end
                    if (w_push) begin
                        w_wptr_nxt = r_wptr + 1'b1;
                    end
                    if (w_pop) begin
                        w_rptr_nxt = r_rptr + 1'b1;
                    end
                end
            end

            S_FLUSH: begin
                // FIFO is already empty here; only the target can change.
                if (bus.redirect) begin
                    w_target_nxt = bus.redirect_pc;
                end
                if (bus.imem_ack) begin
                    w_state_nxt    = S_RUN;
                    w_fetch_pc_nxt = bus.redirect ? bus.redirect_pc : r_target;
                end
            end

            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= S_BOOT;
            r_fetch_pc <= 32'd0;
            r_target   <= 32'd0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_target   <= w_target_nxt;
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
        end
    end

    // FIFO storage: contents need no reset, visibility is set by the pointers.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_pc_mem[r_wptr[AW-1:0]]   <= r_fetch_pc;
            r_word_mem[r_wptr[AW-1:0]] <= bus.imem_rdata;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Prefetching instruction-fetch front end that sits directly upstream of the processor datapath. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. Fetched words are buffered in a small FIFO and presented to decode with a valid/ready handshake, each word tagged with its PC. A redirect from the branch/jump logic flushes the buffer and restarts fetch at a new word address.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `CLK`  in  1  single clock, rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `startPC`  in  32  boot word address; sampled on the first rising edge after `RESET` deasserts.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  word address of the request; stable while `imem_req` is high.
- `imem_ack`  in  1  request complete this cycle; may assert in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word; valid only when `imem_req & imem_ack`.
- `redirect`  in  1  one-cycle pulse: branch or jump taken.
- `redirect_pc`  in  32  new fetch word address; valid with `redirect`.
- `instr_valid`  out  1  `instr` and `instr_pc` hold a valid entry.
- `instr`  out  32  instruction word at the FIFO head.
- `instr_pc`  out  32  word address of `instr`.
- `instr_ready`  in  1  decode accepts the head entry this cycle.

## Operation
- PC is a word address; sequential fetch adds 1 (mod 2^32, so 0xFFFFFFFF wraps to 0).
- FIFO entry = {pc[31:0], word[31:0]}. Pointers have log2(DEPTH)+1 bits so full and empty are distinguishable.
- **Handshakes:**
  - A fetch completes on an edge where `imem_req & imem_ack`.
  - A dequeue happens on an edge where `instr_valid & instr_ready`.
- At most one fetch is outstanding. `imem_req` is never withdrawn before its ack.
- **States:**
  - **BOOT** (reset state): `imem_req` = 0. On the first edge with `RESET` high, fetch_pc <= `startPC` and the state goes to RUN. `redirect` is ignored in BOOT.
  - **RUN:** `imem_req` = (count < DEPTH) and `imem_addr` = fetch_pc.
    - On ack: push {fetch_pc, `imem_rdata`} and fetch_pc += 1.
    - Since count only decreases via dequeue, a raised `imem_req` stays high until ack.
  - **FLUSH:** entered on `redirect` while `imem_req` is high without `imem_ack`.
    - The stale request stays asserted at its old address.
    - Its ack data is discarded and fetch_pc is not incremented.
    - On that ack, go to RUN with fetch_pc = the saved target.
- **Redirect in RUN:** FIFO is emptied; target latched; any same-cycle dequeue is irrelevant.
  - No request pending, or req&ack in the same cycle: ack data is dropped, fetch_pc <= `redirect_pc`, stay in RUN.
  - Request pending with no ack: go to FLUSH as above.
- **Redirect in FLUSH:** the saved target is overwritten with the newer `redirect_pc`.
- **Simultaneous push and pop** with the FIFO full: not possible, because no request issues while full.
- **Simultaneous push and pop** otherwise: both take effect and count is unchanged.

## Timing
- **Reset values:**
  - `imem_req` = 0, `imem_addr` = 0.
  - `instr_valid` = 0, `instr` = 0, `instr_pc` = 0.
  - FIFO empty, state BOOT.
- **Reset mid-operation:** all of the above takes effect immediately (asynchronous). An in-flight request is abandoned. Instruction memory is reset from the same `RESET`.
- **Boot sequence:**
  - Edge E0 (first edge with `RESET` high): PC loaded.
  - `imem_req` is high from E0 onward with `imem_addr` = `startPC`.
- **Fetch-to-decode latency:** word acked at edge N gives `instr_valid` = 1 after edge N (registered FIFO, no bypass).
- **Throughput:** 1 instruction per cycle with a zero-wait memory.
- **Redirect timing:**
  - `instr_valid` is 0 in the cycle after the `redirect` edge.
  - No pending fetch: first request to `redirect_pc` is issued in that same cycle.
  - FLUSH: first request to `redirect_pc` is issued in the cycle after the stale ack.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When the FIFO is empty and a fetch completes, `instr_valid`/`instr`/`instr_pc` are driven combinationally from `imem_rdata` and `imem_addr` in that cycle.
  - If `instr_ready` is also high, the word is consumed without being pushed. Otherwise it is pushed as normal.
  - Fetch-to-decode latency becomes 0 cycles.
  - Bypass is suppressed in any cycle with `redirect` or in FLUSH.
- Not defined: no combinational path from `imem_*` to `instr_*`; latency is 1 cycle as in Timing.

## Test plan
- **Boot:** `startPC` = 0x40, zero-wait memory, `instr_ready` = 1 → `imem_addr` sequence 0x40, 0x41, 0x42…; `instr_pc` follows one cycle later with matching words.
- **Backpressure:** DEPTH = 4, `instr_ready` = 0 → exactly 4 acks, then `imem_req` = 0. Raising `instr_ready` drains 0x40..0x43 in order and fetch resumes at 0x44.
- **Stale flush:** memory with 3-cycle ack latency, `redirect` to 0x100 one cycle after a request to 0x45 issues → the 0x45 data is never presented; next `imem_addr` = 0x100; first `instr_pc` = 0x100.
- **Redirect with simultaneous dequeue and ack:** FIFO holds 2 entries, `redirect_pc` = 0x200 → `instr_valid` = 0 the next cycle; the acked word is dropped; the next request is to 0x200.
- **Wrap and reset:**
  - `startPC` = 0xFFFFFFFE → PCs 0xFFFFFFFE, 0xFFFFFFFF, 0x0.
  - `RESET` low mid-fetch → all outputs 0 immediately; reboot from the new `startPC`.
- **`FETCH_BYPASS_EN`:** empty FIFO, ack at 0x40 → `instr_valid` = 1 with `instr_pc` = 0x40 in the same cycle.
